// File: rtl/mat_iscan_if.sv
// rtl/mat_iscan_if.sv - sample stream bundle for the inverse zig-zag scanner
// Zig-zag ordered samples come in, raster ordered samples go out; no back-pressure.
interface mat_iscan_if #(
  parameter int DW = 10
);
  logic          vld_in;
  logic [DW-1:0] din;
  logic          vld_out;
  logic [DW-1:0] dout;

  modport master (
    output vld_in,
    output din,
    input  vld_out,
    input  dout
  );

  modport slave (
    input  vld_in,
    input  din,
    output vld_out,
    output dout
  );
endinterface

// File: rtl/mat_iscan.sv
// rtl/mat_iscan.sv - inverse zig-zag scanner, 8x8 blocks, ping-pong buffered
// Writes scatter through the zig-zag LUT; reads walk the finished bank linearly.
module mat_iscan #(
  parameter int DW = 10
) (
  input  logic       clk,
  input  logic       rst,
  mat_iscan_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  // Zig-zag index -> raster position (row*8 + col).
  function automatic logic [5:0] zz_lut(input logic [5:0] k);
    logic [5:0] r;
    case (k)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  default: r = 6'd63;
    endcase
    return r;
  endfunction

  // Two banks flattened: address = {bank, raster position}. Not reset.
  logic [DW-1:0] mem_q [0:127];

  logic          wr_bank_q, wr_bank_d;
  logic [5:0]    wr_cnt_q,  wr_cnt_d;
  logic          blk_full;
  logic [6:0]    wr_addr;

  state_t        state_q, state_d;
  logic          rd_bank_q, rd_bank_d;
  logic [5:0]    rd_cnt_q,  rd_cnt_d;
  logic [6:0]    rd_addr;
  logic          vld_out_q, vld_out_d;
  logic [DW-1:0] dout_q,    dout_d;

  assign wr_addr = {wr_bank_q, zz_lut(wr_cnt_q)};
  assign rd_addr = {rd_bank_q, rd_cnt_q};

  always_ff @(posedge clk) begin
    if (bus.vld_in) begin
      mem_q[wr_addr] <= bus.din;
    end
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    blk_full  = bus.vld_in && (wr_cnt_q == 6'd63);
    if (bus.vld_in) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
    end
    if (blk_full) begin
      wr_bank_d = ~wr_bank_q;
    end
  end

  // blk_full is combinational so the read starts on the edge that stores sample 63.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    vld_out_d = 1'b0;
    dout_d    = dout_q;
    case (state_q)
      S_IDLE: begin
        if (blk_full) begin
          state_d   = S_READ;
          rd_bank_d = wr_bank_q;
          rd_cnt_d  = 6'd0;
        end
      end
      S_READ: begin
        vld_out_d = 1'b1;
        dout_d    = mem_q[rd_addr];
        rd_cnt_d  = rd_cnt_q + 6'd1;
        if (rd_cnt_q == 6'd63) begin
          if (blk_full) begin
            rd_bank_d = wr_bank_q;
            rd_cnt_d  = 6'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= 6'd0;
      state_q   <= S_IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 6'd0;
      vld_out_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      vld_out_q <= vld_out_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.vld_out = vld_out_q;
  assign bus.dout    = dout_q;

endmodule

// File: tb/tb_mat_iscan.sv
// tb/tb_mat_iscan.sv - self-checking bench for mat_iscan
// Reference builds the zig-zag walk by diagonals and predicts each output edge.
module tb_mat_iscan;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_iscan_if #(.DW(DW)) bus ();
  mat_iscan #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            edge_n;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  int            zz2r[64];
  int            r2zz[64];
  logic [DW-1:0] blk[64];
  logic [DW-1:0] hold;
  int            k_in;
  int            e;
  int            n_out;
  int            checks;
  int            errors;

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check the edge just passed, then drive the next edge's inputs.
  task automatic step(input logic v, input logic [DW-1:0] d);
    exp_t x;
    @(negedge clk);
    if (expq.size() > 0 && expq[0].edge_n == e) begin
      x = expq.pop_front();
      chk("vld_out_hi", 32'(bus.vld_out), 32'd1);
      chk("dout_raster", 32'(bus.dout), 32'(x.data));
      hold = x.data;
      n_out++;
    end else begin
      chk("vld_out_lo", 32'(bus.vld_out), 32'd0);
      chk("dout_hold", 32'(bus.dout), 32'(hold));
    end
    bus.vld_in = v;
    bus.din    = d;
    if (v) begin
      blk[k_in] = d;
      k_in++;
      if (k_in == 64) begin
        for (int r = 0; r < 64; r++) begin
          x.edge_n = e + 2 + r;
          x.data   = blk[r2zz[r]];
          expq.push_back(x);
        end
        k_in = 0;
      end
    end
    e++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      step(1'b0, '0);
      n++;
    end
    chk("drain_timeout", 32'(expq.size()), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst        = 1'b1;
    bus.vld_in = 1'b0;
    #1;
    chk({tag, "_vld_out"}, 32'(bus.vld_out), 32'd0);
    chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    e++;
    expq.delete();
    k_in = 0;
    hold = '0;
  endtask

  initial begin
    int k, lo, hi, cnt, n;
    logic v;
    checks = 0;
    errors = 0;
    k_in   = 0;
    hold   = '0;
    n_out  = 0;

    // Zig-zag walk: anti-diagonal s, direction alternating with parity of s.
    k = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int row = hi; row >= lo; row--) begin
          zz2r[k] = row * 8 + (s - row);
          k++;
        end
      end else begin
        for (int row = lo; row <= hi; row++) begin
          zz2r[k] = row * 8 + (s - row);
          k++;
        end
      end
    end
    for (int i = 0; i < 64; i++) r2zz[zz2r[i]] = i;

    rst        = 1'b1;
    bus.vld_in = 1'b0;
    bus.din    = '0;
    #1;
    chk("reset_vld_out", 32'(bus.vld_out), 32'd0);
    chk("reset_dout", 32'(bus.dout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    e   = 0;

    for (int i = 0; i < 64; i++) step(1'b1, DW'(i));
    drain();

    for (int i = 0; i < 192; i++) step(1'b1, DW'(i));
    drain();

    for (int i = 0; i < 256; i++) step(i % 2 == 0, rnd());
    drain();

    for (int i = 0; i < 40; i++) step(1'b1, rnd());
    for (int i = 0; i < 65; i++) step(1'b0, '0);
    for (int i = 0; i < 24; i++) step(1'b1, rnd());
    drain();

    for (int i = 0; i < 64; i++) step(1'b1, rnd());
    n_out = 0;
    n = 0;
    while (n_out < 20 && n < 100) begin
      step(1'b0, '0);
      n++;
    end
    chk("mid_read_reached", 32'(n_out), 32'd20);
    do_reset("rst_mid_read");
    for (int i = 0; i < 30; i++) step(1'b1, rnd());
    do_reset("rst_mid_write");
    for (int i = 0; i < 64; i++) step(1'b1, rnd());
    drain();

    step(1'b1, 10'h200);
    for (int i = 1; i < 63; i++) step(1'b1, rnd());
    step(1'b1, 10'h3FF);
    drain();

    cnt = 0;
    while (cnt < 320) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, rnd());
      if (v) cnt++;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mat_iscan.md
# mat_iscan

Inverse zig-zag scanner for 8x8 coefficient blocks: it accepts a stream of DW-bit samples in zig-zag order and re-emits each block in raster (row-major) order. It is the decode-side counterpart of `mat_scan` and sits directly after it, or after any zig-zag-ordered source, in the block-transform datapath. A ping-pong pair of 64-entry buffers lets input and output run concurrently at up to one sample per clock, so no back-pressure is needed.

## Interface
- `DW`, 10, sample width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `vld_in`  input  1  qualifies `din`; a sample is accepted on every rising edge with `vld_in`=1.
- `din`  input  DW  sample in zig-zag order, index k = 0..63 within the current block.
- `vld_out`  output  1  qualifies `dout`.
- `dout`  output  DW  sample in raster order, position r = 0..63 within the block (r = row*8 + col).

## Operation
- Storage is two banks of 64 x DW each (`bank0`, `bank1`); reset does not clear them.
- Write side:
  - Holds `wr_bank` (1 bit) and `wr_cnt` (6 bits).
  - On each accepted sample, writes `din` into `mem[wr_bank][ZZ[wr_cnt]]`, where `ZZ` is the fixed zig-zag-to-raster LUT (see below). `wr_cnt` then increments.
  - When `wr_cnt`=63 is accepted, `wr_cnt` wraps to 0, `wr_bank` toggles, and a one-cycle `blk_full` pulse is raised for the just-completed bank.
- Gaps in `vld_in` are allowed anywhere, including mid-block. A gap simply pauses `wr_cnt`.
- Read side has two states:
  - IDLE → READ on `blk_full`: latch `rd_bank` = completed bank, `rd_cnt` = 0.
  - READ: each cycle, `dout` <= `mem[rd_bank][rd_cnt]`, `vld_out` <= 1, `rd_cnt` increments.
  - READ → IDLE after `rd_cnt`=63 is issued. If `blk_full` fires in that same cycle, go straight back to READ with the other bank and `rd_cnt`=0, with no bubble.
- Overlap is safe by construction. A bank needs ≥64 cycles to fill and 64 cycles to drain, so a refill can never overtake the read of the same bank, and `blk_full` never occurs while READ has more than one entry left.
- Zig-zag mapping, given as the zig-zag index at each raster position, row by row:
  - row 0: 0 1 5 6 14 15 27 28
  - row 1: 2 4 7 13 16 26 29 42
  - row 2: 3 8 12 17 25 30 41 43
  - row 3: 9 11 18 24 31 40 44 53
  - row 4: 10 19 23 32 39 45 52 54
  - row 5: 20 22 33 38 46 51 55 60
  - row 6: 21 34 37 47 50 56 59 61
  - row 7: 35 36 48 49 57 58 62 63
  - `ZZ` is the inverse of this table, e.g. `ZZ[2]`=8, `ZZ[3]`=16, `ZZ[63]`=63.

## Timing
- Reset values: `vld_out`=0, `dout`=0, `wr_cnt`=0, `wr_bank`=0, `rd_cnt`=0, `rd_bank`=0, state IDLE.
- Asserting `rst` at any point discards any partial or in-flight block. Outputs go to their reset values immediately, without waiting for a clock edge.
- Latency: if the 64th sample of a block is accepted at edge N, then `vld_out`=1 after edges N+1 through N+64, with raster position r on `dout` after edge N+1+r. `vld_out` falls after edge N+65 unless the next block's read follows back-to-back.
- `dout` holds its last value while `vld_out`=0.
- Throughput: one sample per cycle sustained. With continuous input, `vld_out` stays high continuously from edge 65 onward.
- `blk_full` and the read-state transitions are internal signals and are not observable at the ports.

## Test plan
- Reset, then continuous input of 64 samples with `din`=k (values 0..63) → `vld_out` rises one edge after the last input. `dout` sequence is 0,1,5,6,14,15,27,28,2,4,7,13,… ending in 62,63 (the raster table above read row by row). Exactly 64 valid cycles.
- Continuous input of 192 samples with `din` incrementing from 0 → 192 contiguous valid outputs with no bubbles. Block b output equals block 0's pattern plus 64·b.
- `vld_in` toggled 1/0 every cycle for 128 samples → same output sequence as continuous input. Each block's output burst is contiguous and starts one edge after that block's 64th accepted sample.
- Input stalls for 65 cycles after 40 samples, then resumes → no output until the 64th sample is accepted, after which the block is correctly ordered. Bank pointers stay intact.
- Assert `rst` mid-read (after 20 valid outputs) and mid-write (after 30 inputs) → `vld_out`=0 and `dout`=0 immediately. The next 64 inputs produce one correct block with `din`-relative ordering restarting at k=0.
- Input value 10'h3FF at zig-zag index 63 and 10'h200 at index 0 → 10'h3FF appears as the last output and 10'h200 as the first, confirming full-width data integrity.
